exe_stage_mc: RTL and testbench
===============================

# exe_stage_mc

Parametrised multi-cycle execute stage for the MIPS datapath pipeline, sitting between the ID/EXE and EXE/MEM pipeline registers. Resolves operand forwarding from a configurable number of downstream sources and executes single-cycle ALU operations. Adds iterative multiply, unsigned divide and unsigned remainder. A registered valid handshake and a stall output freeze upstream stages while a multi-cycle operation is in flight.

## Interface
Parameters:
- WORD_LEN, 32: datapath width in bits; must be ≥ 4 and a power of 2.
- FWD_SRCS, 2: number of forwarding sources (source 1 = EXE/MEM ALU result, source 2 = WB result, further sources appended); ≥ 1.
- SEL_LEN, derived $clog2(FWD_SRCS+1): width of each forwarding select.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction presented this cycle.
- exe_cmd  in  4  operation code (package encoding).
- val1, val2  in  WORD_LEN  register-file operands from ID/EXE.
- st_value_in  in  WORD_LEN  store data from ID/EXE.
- val1_sel, val2_sel, st_val_sel  in  SEL_LEN  forwarding selects: 0 = own input, k = fwd_data source k.
- fwd_data  in  FWD_SRCS*WORD_LEN  flattened forwarding sources; source k occupies bits [k*WORD_LEN-1 : (k-1)*WORD_LEN].
- stall  out  1  stage busy; upstream holds its instruction.
- out_valid  out  1  alu_result/st_value_out valid this cycle.
- alu_result  out  WORD_LEN  registered result.
- st_value_out  out  WORD_LEN  registered forwarded store data.

## Operation
- Codes: ADD 0, SUB 1, AND 2, OR 3, NOR 4, XOR 5, SLL 6, SRL 7, SRA 8, MUL 9, DIVU 10, REMU 11, NOP 15. Codes 12–14 are treated as NOP.
- Forwarding: a select value > FWD_SRCS falls back to the own input (0). Mux outputs are captured into internal operand registers at acceptance.
- Acceptance: an instruction is accepted when in_valid=1 and stall=0. When stall=1, in_valid is ignored and upstream must hold its inputs.
- Single-cycle ops: add/sub wrap modulo 2^WORD_LEN, with no overflow flag. Shift amount is val2[$clog2(WORD_LEN)-1:0]; SRA is arithmetic. NOP produces out_valid=1 with alu_result=0.
- MUL: shift-add, one bit per cycle; result is the low WORD_LEN bits of the product.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- Divide by zero: DIVU returns all-ones and REMU returns the dividend. The iteration count is unchanged.
- FSM states:
  - IDLE: accept; a single-cycle op stays IDLE; MUL/DIVU/REMU load the counter with WORD_LEN and go to ITER.
  - ITER: one step per cycle and decrement the counter; at counter=1 go to IDLE and register the result.
- stall = (state == ITER), driven from the register with no combinational path from in_valid.
- st_value_out always carries the forwarded store value captured at acceptance of the same instruction.

## Timing
- Reset: state IDLE, counter 0, stall 0, out_valid 0, alu_result 0, st_value_out 0.
- Single-cycle op accepted at cycle T: out_valid=1 at T+1 for exactly one cycle. Back-to-back acceptance every cycle is supported.
- Multi-cycle op accepted at T:
  - stall=1 during T+1 … T+WORD_LEN.
  - out_valid=1 with the result at T+WORD_LEN+1, when stall=0.
  - A new instruction may be accepted in that same cycle T+WORD_LEN+1.
- out_valid is 0 in all cycles not listed above. alu_result and st_value_out hold their last values while out_valid=0.
- rst asserted mid-operation aborts it. The next cycle shows reset values and no out_valid for the aborted op.
- rst takes priority over a simultaneous in_valid; that instruction is dropped.

## Structure
- Shared package exe_pkg: exe_cmd codes, EXE_CMD_LEN=4, FSM state enum.
- Sub-module fwd_mux (parametrised WORD_LEN, FWD_SRCS): instantiated three times for val1, val2 and st_value.
- The iterative mul/div datapath stays inline in exe_stage_mc.

## Test plan
- WORD_LEN=32, FWD_SRCS=2:
  - ADD val1=5, val2=7, sels 0 → out_valid at T+1, alu_result=12; SUB 3−5 → 0xFFFFFFFE.
  - val1_sel=1 (fwd_data source 1 = 0x10), val2_sel=2 (source 2 = 0x3), st_val_sel=3 (out of range, falls back to st_value_in=0xAB), ADD → alu_result=0x13, st_value_out=0xAB.
  - MUL 0xFFFF×0x10001 → stall high for 32 cycles, out_valid at T+33 with 0xFFFFFFFF. A single-cycle op accepted at T+33 gives out_valid at T+34.
  - DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9; each result at T+33.
- WORD_LEN=32, FWD_SRCS=1:
  - SRA 0x80000000 by 31 → 0xFFFFFFFF; SRL same → 1; with val2=0x25, shift count 5 is used.
- WORD_LEN=8, FWD_SRCS=3:
  - MUL 13×11 → 0x8F at T+9.
  - rst at T+4 of a DIVU → stall=0 and out_valid=0 from the next cycle, and no result is ever emitted for the aborted op.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage:
// operation codes, FSM states and a multi-cycle op classifier.
package exe_pkg;

   localparam int EXE_CMD_LEN = 4;

   typedef enum logic [EXE_CMD_LEN-1:0] {
      CMD_ADD  = 4'd0,
      CMD_SUB  = 4'd1,
      CMD_AND  = 4'd2,
      CMD_OR   = 4'd3,
      CMD_NOR  = 4'd4,
      CMD_XOR  = 4'd5,
      CMD_SLL  = 4'd6,
      CMD_SRL  = 4'd7,
      CMD_SRA  = 4'd8,
      CMD_MUL  = 4'd9,
      CMD_DIVU = 4'd10,
      CMD_REMU = 4'd11,
      CMD_NOP  = 4'd15
   } exe_cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } exe_state_e;

   function automatic logic is_multi(input logic [EXE_CMD_LEN-1:0] c);
      return (c == CMD_MUL) || (c == CMD_DIVU) || (c == CMD_REMU);
   endfunction

endpackage

// File: rtl/exe_stage_mc_fwd_mux.sv
// Forwarding mux: picks own_i (sel 0 or out of range) or fwd source k.
// Ports: sel_i select, own_i own operand, fwd_i flattened sources, data_o.
module fwd_mux #(
   parameter int WORD_LEN = 32,
   parameter int FWD_SRCS = 2,
   localparam int SEL_LEN = $clog2(FWD_SRCS + 1)
) (
   input  logic [SEL_LEN-1:0]           sel_i,
   input  logic [WORD_LEN-1:0]          own_i,
   input  logic [FWD_SRCS*WORD_LEN-1:0] fwd_i,
   output logic [WORD_LEN-1:0]          data_o
);

   always_comb begin
      data_o = own_i;
      for (int k = 1; k <= FWD_SRCS; k++) begin
         if (sel_i == SEL_LEN'(k)) begin
            data_o = fwd_i[k*WORD_LEN-1 -: WORD_LEN];
         end
      end
   end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with forwarding, single-cycle ALU and iterative mul/divu/remu.
// Ports: clk/rst, in_valid+exe_cmd+operands+selects in; stall, out_valid, results out.
module exe_stage_mc
   import exe_pkg::*;
#(
   parameter int WORD_LEN = 32,
   parameter int FWD_SRCS = 2,
   localparam int SEL_LEN = $clog2(FWD_SRCS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [EXE_CMD_LEN-1:0]       exe_cmd,
   input  logic [WORD_LEN-1:0]          val1,
   input  logic [WORD_LEN-1:0]          val2,
   input  logic [WORD_LEN-1:0]          st_value_in,
   input  logic [SEL_LEN-1:0]           val1_sel,
   input  logic [SEL_LEN-1:0]           val2_sel,
   input  logic [SEL_LEN-1:0]           st_val_sel,
   input  logic [FWD_SRCS*WORD_LEN-1:0] fwd_data,
   output logic                         stall,
   output logic                         out_valid,
   output logic [WORD_LEN-1:0]          alu_result,
   output logic [WORD_LEN-1:0]          st_value_out
);

   localparam int SHW  = $clog2(WORD_LEN);
   localparam int CNTW = SHW + 1;

   logic [WORD_LEN-1:0] op_a, op_b, op_st;

   fwd_mux #(.WORD_LEN(WORD_LEN), .FWD_SRCS(FWD_SRCS)) u_fwd_a (
      .sel_i(val1_sel), .own_i(val1), .fwd_i(fwd_data), .data_o(op_a));
   fwd_mux #(.WORD_LEN(WORD_LEN), .FWD_SRCS(FWD_SRCS)) u_fwd_b (
      .sel_i(val2_sel), .own_i(val2), .fwd_i(fwd_data), .data_o(op_b));
   fwd_mux #(.WORD_LEN(WORD_LEN), .FWD_SRCS(FWD_SRCS)) u_fwd_st (
      .sel_i(st_val_sel), .own_i(st_value_in), .fwd_i(fwd_data), .data_o(op_st));

   exe_state_e          state_q, state_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   exe_cmd_e            cmd_q, cmd_d;
   // acc: product accumulator / partial remainder
   // opb: multiplicand (shifts left) / divisor
   // quo: multiplier (shifts right) / dividend-quotient shift register
   logic [WORD_LEN-1:0] acc_q, acc_d;
   logic [WORD_LEN-1:0] opb_q, opb_d;
   logic [WORD_LEN-1:0] quo_q, quo_d;
   logic [WORD_LEN-1:0] st_q, st_d;
   logic [WORD_LEN-1:0] res_q, res_d;
   logic [WORD_LEN-1:0] sto_q, sto_d;
   logic                vld_q, vld_d;

   logic [SHW-1:0]      sh;
   logic [WORD_LEN-1:0] sc_res;
   logic [WORD_LEN-1:0] acc_mul;
   logic [WORD_LEN:0]   trial;
   logic                ge;
   logic [WORD_LEN-1:0] rem_n, quo_n;

   assign sh = op_b[SHW-1:0];

   always_comb begin
      sc_res = '0;
      case (exe_cmd_e'(exe_cmd))
         CMD_ADD: sc_res = op_a + op_b;
         CMD_SUB: sc_res = op_a - op_b;
         CMD_AND: sc_res = op_a & op_b;
         CMD_OR:  sc_res = op_a | op_b;
         CMD_NOR: sc_res = ~(op_a | op_b);
         CMD_XOR: sc_res = op_a ^ op_b;
         CMD_SLL: sc_res = op_a << sh;
         CMD_SRL: sc_res = op_a >> sh;
         CMD_SRA: sc_res = $signed(op_a) >>> sh;
         default: sc_res = '0;
      endcase
   end

   // One shift-add step and one restoring-division step.
   // A zero divisor always "fits", giving all-ones quotient and
   // leaving the dividend in the remainder.
   always_comb begin
      acc_mul = acc_q + (quo_q[0] ? opb_q : '0);
      trial   = {acc_q, quo_q[WORD_LEN-1]};
      ge      = trial >= {1'b0, opb_q};
      rem_n   = trial[WORD_LEN-1:0] - (ge ? opb_q : '0);
      quo_n   = {quo_q[WORD_LEN-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      quo_d   = quo_q;
      st_d    = st_q;
      res_d   = res_q;
      sto_d   = sto_q;
      vld_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_multi(exe_cmd)) begin
                  state_d = ST_ITER;
                  cnt_d   = CNTW'(WORD_LEN);
                  cmd_d   = exe_cmd_e'(exe_cmd);
                  acc_d   = '0;
                  opb_d   = op_b;
                  quo_d   = op_a;
                  st_d    = op_st;
               end else begin
                  vld_d = 1'b1;
                  res_d = sc_res;
                  sto_d = op_st;
               end
            end
         end
         ST_ITER: begin
            cnt_d = cnt_q - 1'b1;
            if (cmd_q == CMD_MUL) begin
               acc_d = acc_mul;
               opb_d = opb_q << 1;
               quo_d = quo_q >> 1;
            end else begin
               acc_d = rem_n;
               quo_d = quo_n;
            end
            if (cnt_q == CNTW'(1)) begin
               state_d = ST_IDLE;
               vld_d   = 1'b1;
               sto_d   = st_q;
               if (cmd_q == CMD_MUL) begin
                  res_d = acc_mul;
               end else if (cmd_q == CMD_DIVU) begin
                  res_d = quo_n;
               end else begin
                  res_d = rem_n;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_q   <= CMD_NOP;
         acc_q   <= '0;
         opb_q   <= '0;
         quo_q   <= '0;
         st_q    <= '0;
         res_q   <= '0;
         sto_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         quo_q   <= quo_d;
         st_q    <= st_d;
         res_q   <= res_d;
         sto_q   <= sto_d;
         vld_q   <= vld_d;
      end
   end

   assign stall        = (state_q == ST_ITER);
   assign out_valid    = vld_q;
   assign alu_result   = res_q;
   assign st_value_out = sto_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Scoreboard bench for exe_stage_mc in three configurations:
// A: W32/F2, B: W8/F3, C: W32/F1.
module tb_exe_stage_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      longint unsigned res;
      longint unsigned st;
      int              cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   // Instance A: WORD_LEN=32, FWD_SRCS=2
   logic        a_rst, a_in, a_stall, a_ov;
   logic [3:0]  a_cmd;
   logic [31:0] a_v1, a_v2, a_st, a_res, a_sto;
   logic [1:0]  a_s1, a_s2, a_s3;
   logic [63:0] a_fwd;

   // Instance B: WORD_LEN=8, FWD_SRCS=3
   logic        b_rst, b_in, b_stall, b_ov;
   logic [3:0]  b_cmd;
   logic [7:0]  b_v1, b_v2, b_st, b_res, b_sto;
   logic [1:0]  b_s1, b_s2, b_s3;
   logic [23:0] b_fwd;

   // Instance C: WORD_LEN=32, FWD_SRCS=1
   logic        c_rst, c_in, c_stall, c_ov;
   logic [3:0]  c_cmd;
   logic [31:0] c_v1, c_v2, c_st, c_res, c_sto, c_fwd;
   logic [0:0]  c_s1, c_s2, c_s3;

   exe_stage_mc #(.WORD_LEN(32), .FWD_SRCS(2)) u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in), .exe_cmd(a_cmd),
      .val1(a_v1), .val2(a_v2), .st_value_in(a_st),
      .val1_sel(a_s1), .val2_sel(a_s2), .st_val_sel(a_s3),
      .fwd_data(a_fwd), .stall(a_stall), .out_valid(a_ov),
      .alu_result(a_res), .st_value_out(a_sto));

   exe_stage_mc #(.WORD_LEN(8), .FWD_SRCS(3)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in), .exe_cmd(b_cmd),
      .val1(b_v1), .val2(b_v2), .st_value_in(b_st),
      .val1_sel(b_s1), .val2_sel(b_s2), .st_val_sel(b_s3),
      .fwd_data(b_fwd), .stall(b_stall), .out_valid(b_ov),
      .alu_result(b_res), .st_value_out(b_sto));

   exe_stage_mc #(.WORD_LEN(32), .FWD_SRCS(1)) u_c (
      .clk(clk), .rst(c_rst), .in_valid(c_in), .exe_cmd(c_cmd),
      .val1(c_v1), .val2(c_v2), .st_value_in(c_st),
      .val1_sel(c_s1), .val2_sel(c_s2), .st_val_sel(c_s3),
      .fwd_data(c_fwd), .stall(c_stall), .out_valid(c_ov),
      .alu_result(c_res), .st_value_out(c_sto));

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Reference model: plain arithmetic on w-bit values.
   function automatic longint unsigned model(input int cmd,
         input longint unsigned a, input longint unsigned b, input int w);
      longint unsigned m;
      int sh;
      longint sa;
      m  = (64'd1 << w) - 1;
      sh = int'(b % longint'(w));
      sa = ((a >> (w - 1)) & 1) != 0 ? longint'(a | ~m) : longint'(a);
      case (cmd)
         0:  return (a + b) & m;
         1:  return (a - b) & m;
         2:  return a & b;
         3:  return a | b;
         4:  return ~(a | b) & m;
         5:  return a ^ b;
         6:  return (a << sh) & m;
         7:  return a >> sh;
         8:  return $unsigned(sa >>> sh) & m;
         9:  return (a * b) & m;
         10: return (b == 0) ? m : a / b;
         11: return (b == 0) ? a : a % b;
         default: return 0;
      endcase
   endfunction

   function automatic longint unsigned pick(input int s,
         input longint unsigned own, input longint unsigned f0,
         input longint unsigned f1, input longint unsigned f2, input int f);
      if (s == 0 || s > f) return own;
      if (s == 1) return f0;
      if (s == 2) return f1;
      return f2;
   endfunction

   function automatic logic stall_of(input int inst);
      if (inst == 0) return a_stall;
      if (inst == 1) return b_stall;
      return c_stall;
   endfunction

   task automatic idle_all();
      a_in = 1'b0;
      b_in = 1'b0;
      c_in = 1'b0;
   endtask

   task automatic issue(input int inst, input int cmd,
         input longint unsigned v1, input longint unsigned v2,
         input longint unsigned st, input int s1, input int s2, input int s3,
         input longint unsigned f0, input longint unsigned f1,
         input longint unsigned f2);
      int w, f, n;
      longint unsigned m, o1, o2, o3;
      exp_t e;
      bit multi;
      w = (inst == 1) ? 8 : 32;
      f = (inst == 0) ? 2 : (inst == 1) ? 3 : 1;
      m = (64'd1 << w) - 1;
      v1 &= m; v2 &= m; st &= m; f0 &= m; f1 &= m; f2 &= m;
      o1 = pick(s1, v1, f0, f1, f2, f);
      o2 = pick(s2, v2, f0, f1, f2, f);
      o3 = pick(s3, st, f0, f1, f2, f);
      multi = (cmd == 9) || (cmd == 10) || (cmd == 11);
      chk($sformatf("ready%0d", inst), stall_of(inst), 0);
      e.res = model(cmd, o1, o2, w);
      e.st  = o3;
      e.cyc = cyc + (multi ? w + 1 : 1);
      case (inst)
         0: begin
            a_cmd = 4'(cmd); a_v1 = v1[31:0]; a_v2 = v2[31:0];
            a_st = st[31:0]; a_s1 = 2'(s1); a_s2 = 2'(s2);
            a_s3 = 2'(s3); a_fwd = {f1[31:0], f0[31:0]};
            a_in = 1'b1; qa.push_back(e);
         end
         1: begin
            b_cmd = 4'(cmd); b_v1 = v1[7:0]; b_v2 = v2[7:0];
            b_st = st[7:0]; b_s1 = 2'(s1); b_s2 = 2'(s2);
            b_s3 = 2'(s3); b_fwd = {f2[7:0], f1[7:0], f0[7:0]};
            b_in = 1'b1; qb.push_back(e);
         end
         default: begin
            c_cmd = 4'(cmd); c_v1 = v1[31:0]; c_v2 = v2[31:0];
            c_st = st[31:0]; c_s1 = 1'(s1); c_s2 = 1'(s2);
            c_s3 = 1'(s3); c_fwd = f0[31:0];
            c_in = 1'b1; qc.push_back(e);
         end
      endcase
      @(negedge clk);
      idle_all();
      if (multi) begin
         n = 0;
         while (stall_of(inst) && n < w + 5) begin
            n++;
            @(negedge clk);
         end
         chk($sformatf("stall_len%0d", inst), longint'(n), longint'(w));
      end
   endtask

   always @(negedge clk) begin
      if (a_ov) begin
         if (qa.size() == 0) chk("unexpected_a", 1, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_res", a_res, e.res);
            chk("a_st", a_sto, e.st);
            chk("a_cyc", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (b_ov) begin
         if (qb.size() == 0) chk("unexpected_b", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_res", b_res, e.res);
            chk("b_st", b_sto, e.st);
            chk("b_cyc", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (c_ov) begin
         if (qc.size() == 0) chk("unexpected_c", 1, 0);
         else begin
            exp_t e;
            e = qc.pop_front();
            chk("c_res", c_res, e.res);
            chk("c_st", c_sto, e.st);
            chk("c_cyc", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   initial begin
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      idle_all();
      a_cmd = '0; a_v1 = '0; a_v2 = '0; a_st = '0; a_fwd = '0;
      a_s1 = '0; a_s2 = '0; a_s3 = '0;
      b_cmd = '0; b_v1 = '0; b_v2 = '0; b_st = '0; b_fwd = '0;
      b_s1 = '0; b_s2 = '0; b_s3 = '0;
      c_cmd = '0; c_v1 = '0; c_v2 = '0; c_st = '0; c_fwd = '0;
      c_s1 = '0; c_s2 = '0; c_s3 = '0;
      repeat (3) @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      chk("rst_a_ov", a_ov, 0);
      chk("rst_a_stall", a_stall, 0);
      chk("rst_a_res", a_res, 0);
      chk("rst_a_st", a_sto, 0);
      chk("rst_b_ov", b_ov, 0);
      chk("rst_b_res", b_res, 0);
      chk("rst_c_sto", c_sto, 0);

      // A: directed
      issue(0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 0);
      issue(0, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0);
      issue(0, 0, 1, 2, 'hAB, 1, 2, 3, 'h10, 'h3, 0);
      issue(0, 9, 'hFFFF, 'h10001, 'h55, 0, 0, 0, 0, 0, 0);
      issue(0, 5, 'hF0F0, 'h0FF0, 'h66, 0, 0, 0, 0, 0, 0);
      issue(0, 10, 100, 7, 1, 0, 0, 0, 0, 0, 0);
      issue(0, 11, 100, 7, 2, 0, 0, 0, 0, 0, 0);
      issue(0, 10, 9, 0, 3, 0, 0, 0, 0, 0, 0);
      issue(0, 11, 9, 0, 4, 0, 0, 0, 0, 0, 0);
      issue(0, 15, 1, 1, 5, 0, 0, 0, 0, 0, 0);
      issue(0, 13, 1, 1, 6, 0, 0, 0, 0, 0, 0);
      issue(0, 4, 'h0F, 'hF0, 7, 0, 0, 0, 0, 0, 0);

      // A: random
      for (int i = 0; i < 40; i++) begin
         longint unsigned v2;
         v2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
         issue(0, $urandom_range(0, 15), $urandom, v2, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom, $urandom, 0);
      end

      // C: shifts
      issue(2, 8, 'h80000000, 31, 'h11, 0, 0, 0, 0, 0, 0);
      issue(2, 7, 'h80000000, 31, 'h12, 0, 0, 0, 0, 0, 0);
      issue(2, 8, 'h80000000, 'h25, 'h13, 0, 0, 0, 0, 0, 0);
      issue(2, 6, 'h3, 'h21, 'h14, 0, 0, 1, 'h77, 0, 0);
      issue(2, 0, 'h1, 'h1, 'h15, 1, 1, 0, 'h40, 0, 0);

      // B: directed and random
      issue(1, 9, 13, 11, 'h22, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 25; i++) begin
         issue(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 20),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom, $urandom, $urandom);
      end

      // B: abort a DIVU with reset; nothing may be emitted for it
      b_cmd = 4'd10; b_v1 = 8'd200; b_v2 = 8'd3;
      b_s1 = '0; b_s2 = '0; b_s3 = '0;
      b_in = 1'b1;
      @(negedge clk);
      b_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy", b_stall, 1);
      b_rst = 1'b1;
      @(negedge clk);
      chk("abort_stall", b_stall, 0);
      chk("abort_ov", b_ov, 0);
      chk("abort_res", b_res, 0);
      // instruction during reset is dropped
      b_cmd = 4'd0; b_v1 = 8'd1; b_v2 = 8'd1; b_in = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      b_in = 1'b0;
      chk("rst_prio_ov", b_ov, 0);
      repeat (12) @(negedge clk);
      chk("abort_quiet", b_ov, 0);
      issue(1, 0, 20, 22, 'h5A, 0, 0, 0, 0, 0, 0);

      repeat (4) @(negedge clk);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      chk("qc_empty", qc.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
